// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: FSM state and the owner
// tag that routes synchronous read data back to the requester that issued it.
// `WORD is the global data/address word-range macro.

`ifndef WORD
`define WORD [31:0]
`endif

package imem_arbiter_pkg;

  // Arbiter phase: BOOT (loader only) and RUN (fetch and loader share).
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  // Which requester owns the read data returning on the next cycle.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } owner_t;

  localparam int OWNER_W = 2;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the requesters/memory and the arbiter.
// slave: arbiter view. master: requesters and memory view.

`ifndef WORD
`define WORD [31:0]
`endif

interface imem_arbiter_if #(
  parameter int IMEM_POWER = 18
);
  // fetch port
  logic                  f_req;
  logic `WORD            f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic `WORD            f_rdata;
  logic                  stallF;
  // loader port
  logic                  l_req;
  logic                  l_we;
  logic `WORD            l_addr;
  logic `WORD            l_wdata;
  logic                  l_gnt;
  logic                  l_rvalid;
  logic `WORD            l_rdata;
  // boot control / status
  logic                  boot_done;
  logic                  running;
  // memory port
  logic                  m_en;
  logic                  m_we;
  logic [IMEM_POWER-1:0] m_addr;
  logic `WORD            m_wdata;
  logic `WORD            m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, boot_done, m_rdata,
    output f_gnt, f_rvalid, f_rdata, stallF, l_gnt, l_rvalid, l_rdata,
           running, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, boot_done, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, stallF, l_gnt, l_rvalid, l_rdata,
           running, m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive loader wins while fetch waits.
// Only instantiated when IMEM_ARB_STARVE_EN is defined.

module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Clear wins; otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = '0;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  flopr #(.WIDTH(CNT_W), .RESET_VAL('0)) u_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/flopr.sv
// Resettable register: asynchronous active-high reset to RESET_VAL.

module flopr #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d every cycle; reset forces the initial value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RESET_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one synchronous-read memory between the
// fetch port and the boot/loader port. BOOT grants only the loader; RUN lets
// the loader win ties. Optional macro IMEM_ARB_STARVE_EN forces a fetch grant
// after STARVE_MAX consecutive loader wins over a waiting fetch.

`ifndef WORD
`define WORD [31:0]
`endif

module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int IMEM_POWER = 18,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  imem_arbiter_if.slave    bus
);

  arb_state_t        state_q;
  logic              running_q;
  logic              starve_force;
  logic              f_gnt_c;
  logic              l_gnt_c;
  logic `WORD        sel_addr;
  owner_t            owner_d;
  owner_t            owner_q;
  logic [OWNER_W-1:0] owner_raw_q;

  // Phase FSM: BOOT until boot_done, then RUN until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: if (bus.boot_done) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        default: begin
          state_q   <= BOOT;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Grants: fetch only in RUN, and only if loader idle or starvation forces it.
  always_comb begin
    f_gnt_c = (state_q == RUN) && bus.f_req && (!bus.l_req || starve_force);
    l_gnt_c = bus.l_req && !f_gnt_c;
  end

  // Memory port mux from the granted requester; fetch is always a read.
  always_comb begin
    sel_addr    = bus.l_addr;
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_wdata = '0;
    if (f_gnt_c) begin
      bus.m_en = 1'b1;
      sel_addr = bus.f_addr;
    end else if (l_gnt_c) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.l_we;
      bus.m_wdata = bus.l_wdata;
    end
  end

  // Word index; byte-offset bits and bits above the memory depth wrap away.
  assign bus.m_addr = sel_addr[IMEM_POWER+1:2];

  // Owner of next cycle's read data; writes return nothing.
  always_comb begin
    owner_d = NONE;
    if (f_gnt_c)                   owner_d = FETCH;
    else if (l_gnt_c && !bus.l_we) owner_d = LOAD;
  end

  flopr #(.WIDTH(OWNER_W), .RESET_VAL(NONE)) u_owner_reg (
    .clk   (clk),
    .reset (reset),
    .d     (owner_d),
    .q     (owner_raw_q)
  );

  assign owner_q = owner_t'(owner_raw_q);

  assign bus.f_gnt    = f_gnt_c;
  assign bus.l_gnt    = l_gnt_c;
  assign bus.stallF   = bus.f_req && !f_gnt_c;
  assign bus.running  = running_q;
  assign bus.f_rvalid = (owner_q == FETCH);
  assign bus.l_rvalid = (owner_q == LOAD);
  assign bus.f_rdata  = bus.m_rdata;
  assign bus.l_rdata  = bus.m_rdata;

`ifdef IMEM_ARB_STARVE_EN
  logic cnt_inc;
  logic cnt_clr;

  // Count RUN loader wins over a waiting fetch; any fetch grant or idle fetch clears.
  always_comb begin
    cnt_inc = (state_q == RUN) && l_gnt_c && bus.f_req;
    cnt_clr = f_gnt_c || !bus.f_req;
  end

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (starve_force)
  );
`else
  logic [31:0] unused_starve_max;
  assign starve_force      = 1'b0;
  assign unused_starve_max = 32'(STARVE_MAX);
`endif

  // Address bits that the wrap-around deliberately discards.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{bus.f_addr[1:0], bus.l_addr[1:0]};

  generate
    if (IMEM_POWER < 30) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{bus.f_addr[31:IMEM_POWER+2], bus.l_addr[31:IMEM_POWER+2]};
    end
  endgenerate

endmodule
